// File: rtl/hwt_scan_pkg.sv
// hwt_scan_pkg: shared types, sizes and golden function for the non_hwt cone scanner.
package hwt_scan_pkg;
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
    localparam int NUM_VEC = 16;
    localparam int VEC_W = 4;
    localparam logic [NUM_VEC-1:0] GOLDEN_MAP = 16'hA888;
    function automatic logic golden(input logic [VEC_W-1:0] vec);
        return vec[0] & ((vec[3] & vec[2]) | vec[1]);
    endfunction
endpackage

// File: rtl/hwt_scan_ctrl.sv
// hwt_scan_ctrl: exhaustive 16-vector scan of the non_hwt cone with golden compare.
// Optional HWT_SCAN_LOG_EN adds the per-vector fail_map port and register.
module hwt_scan_ctrl
    import hwt_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             dut_y,
    output logic [VEC_W-1:0] vec_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [4:0]       err_cnt,
    output logic [VEC_W-1:0] first_fail,
    output logic             first_fail_vld
`ifdef HWT_SCAN_LOG_EN
    ,
    output logic [NUM_VEC-1:0] fail_map
`endif
);
    localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

    state_t           state, state_d;
    logic [VEC_W-1:0] idx, idx_d, ff_d, vec_d;
    logic [3:0]       cnt, cnt_d;
    logic [4:0]       err_d;
    logic             ffv_d, busy_d, done_d, pass_d, mis;
`ifdef HWT_SCAN_LOG_EN
    logic [NUM_VEC-1:0] map_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= '0;
            cnt            <= '0;
            err_cnt        <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
            vec_out        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
        end else begin
            state          <= state_d;
            idx            <= idx_d;
            cnt            <= cnt_d;
            err_cnt        <= err_d;
            first_fail     <= ff_d;
            first_fail_vld <= ffv_d;
            vec_out        <= vec_d;
            busy           <= busy_d;
            done           <= done_d;
            pass           <= pass_d;
        end
    end

`ifdef HWT_SCAN_LOG_EN
    always_ff @(posedge clk) begin
        if (rst) fail_map <= '0;
        else     fail_map <= map_d;
    end
`endif

    always_comb begin
        state_d = state;
        idx_d   = idx;
        cnt_d   = cnt;
        err_d   = err_cnt;
        ff_d    = first_fail;
        ffv_d   = first_fail_vld;
`ifdef HWT_SCAN_LOG_EN
        map_d   = fail_map;
`endif
        mis     = dut_y != golden(idx);
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state)
                IDLE, DONE: if (start) begin
                    state_d = DRIVE;
                    idx_d   = '0;
                    cnt_d   = SETTLE;
                    err_d   = '0;
                    ff_d    = '0;
                    ffv_d   = 1'b0;
`ifdef HWT_SCAN_LOG_EN
                    map_d   = '0;
`endif
                end
                DRIVE: begin
                    cnt_d   = cnt - 4'd1;
                    state_d = (cnt <= 4'd1) ? SAMPLE : DRIVE;
                end
                SAMPLE: begin
                    if (mis) begin
                        err_d = err_cnt + 5'd1;
`ifdef HWT_SCAN_LOG_EN
                        map_d[idx] = 1'b1;
`endif
                        ff_d  = first_fail_vld ? first_fail : idx;
                        ffv_d = 1'b1;
                    end
                    state_d = (idx == 4'd15) ? DONE : DRIVE;
                    idx_d   = (idx == 4'd15) ? idx : idx + 4'd1;
                    cnt_d   = SETTLE;
                end
                default: state_d = IDLE;
            endcase
        end
        // Outputs are registered from next-state so they line up with the state they describe.
        busy_d = (state_d == DRIVE) || (state_d == SAMPLE);
        vec_d  = busy_d ? idx_d : '0;
        done_d = state_d == DONE;
        pass_d = done_d && (err_d == 5'd0);
    end
endmodule

// File: tb/tb_hwt_scan_ctrl.sv
// tb_hwt_scan_ctrl: directed scans against golden, stuck-at-0, trojan and inverted cones,
// plus abort/restart, ignored start and mid-scan reset. Honours HWT_SCAN_LOG_EN.
module tb_hwt_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       dut_y;
    logic [3:0] vec_out;
    logic       busy, done, pass;
    logic [4:0] err_cnt;
    logic [3:0] first_fail;
    logic       first_fail_vld;
`ifdef HWT_SCAN_LOG_EN
    logic [15:0] fail_map;
`endif
    int total = 0;
    int bad = 0;
    int mode = 0;
    logic g;

    always #5 clk = ~clk;

    // Cone models: 0 golden, 1 stuck-at-0, 2 trojan on vector 12, 3 inverted.
    assign g = vec_out[0] & ((vec_out[3] & vec_out[2]) | vec_out[1]);
    assign dut_y = (mode == 0) ? g : (mode == 1) ? 1'b0 :
                   (mode == 2) ? (g | (vec_out == 4'b1100)) : ~g;

    hwt_scan_ctrl #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .dut_y(dut_y),
        .vec_out(vec_out), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .first_fail(first_fail), .first_fail_vld(first_fail_vld)
`ifdef HWT_SCAN_LOG_EN
        , .fail_map(fail_map)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy0"}, 32'(busy), 32'd1);
        chk({tag, "_vec0"}, 32'(vec_out), 32'd0);
    endtask

    task automatic wait_done(input string tag, input int pulse_at);
        int n = 0;
        while (!done && n < 200) begin
            start = (n == pulse_at);
            @(negedge clk);
            n++;
            if (n == 4) chk({tag, "_vec1"}, 32'(vec_out), 32'd1);
        end
        start = 1'b0;
        chk({tag, "_lat"}, 32'(n), 32'd48);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_vecz"}, 32'(vec_out), 32'd0);
    endtask

    task automatic chk_res(input string tag, input logic [4:0] e, input logic [3:0] ff,
                           input logic ffv, input logic p, input logic [15:0] m);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_err"}, 32'(err_cnt), 32'(e));
        chk({tag, "_ffv"}, 32'(first_fail_vld), 32'(ffv));
        if (ffv) chk({tag, "_ff"}, 32'(first_fail), 32'(ff));
        chk({tag, "_pass"}, 32'(pass), 32'(p));
`ifdef HWT_SCAN_LOG_EN
        chk({tag, "_map"}, 32'(fail_map), 32'(m));
`else
        if (m == 16'hdead) $display("unused map %0h", m);
`endif
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_vec"}, 32'(vec_out), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pass"}, 32'(pass), 32'd0);
        chk({tag, "_err"}, 32'(err_cnt), 32'd0);
        chk({tag, "_ff"}, 32'(first_fail), 32'd0);
        chk({tag, "_ffv"}, 32'(first_fail_vld), 32'd0);
`ifdef HWT_SCAN_LOG_EN
        chk({tag, "_map"}, 32'(fail_map), 32'd0);
`endif
    endtask

    initial begin
        cycles(3);
        rst = 1'b0;
        chk_reset("rst");
        cycles(2);
        chk("idle_busy", 32'(busy), 32'd0);

        mode = 0;
        do_start("gold");
        wait_done("gold", -1);
        chk_res("gold", 5'd0, 4'd0, 1'b0, 1'b1, 16'h0000);
        cycles(3);
        chk("gold_hold", 32'(done), 32'd1);

        mode = 1;
        do_start("sa0");
        wait_done("sa0", -1);
        chk_res("sa0", 5'd5, 4'd3, 1'b1, 1'b0, 16'hA888);

        mode = 2;
        do_start("troj");
        wait_done("troj", -1);
        chk_res("troj", 5'd1, 4'd12, 1'b1, 1'b0, 16'h1000);

        mode = 3;
        do_start("inv");
        wait_done("inv", -1);
        chk_res("inv", 5'd16, 4'd0, 1'b1, 1'b0, 16'hFFFF);

        // Abort at cycle 10 after start, then restart at cycle 20 with a start pulsed mid-scan.
        mode = 0;
        do_start("ab");
        cycles(9);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_done", 32'(done), 32'd0);
        chk("ab_vec", 32'(vec_out), 32'd0);
        chk("ab_pass", 32'(pass), 32'd0);
        cycles(9);
        chk("ab_idle", 32'(busy), 32'd0);
        do_start("ab2");
        wait_done("ab2", 20);
        chk_res("ab2", 5'd0, 4'd0, 1'b0, 1'b1, 16'h0000);

        // Reset while vector 7 is being driven, after vector 3 has already failed.
        mode = 1;
        do_start("mr");
        cycles(21);
        chk("mr_vec7", 32'(vec_out), 32'd7);
        chk("mr_err1", 32'(err_cnt), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset("mr_rst");
        mode = 0;
        do_start("mr2");
        wait_done("mr2", -1);
        chk_res("mr2", 5'd0, 4'd0, 1'b0, 1'b1, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
